// File: rtl/alu_op_dispatch.sv
// Single-request ALU dispatcher: enables one functional unit, holds operands for a
// settle window, captures that unit's result and returns it over a valid/ready channel.
module alu_op_dispatch #(
  parameter int         WIDTH     = 4,
  parameter int         NUM_UNITS = 8,
  parameter int         SETTLE    = 1,
  parameter logic [7:0] UNIT_MASK = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [2:0]                 req_op,
  input  logic [WIDTH-1:0]           req_a,
  input  logic [WIDTH-1:0]           req_b,
  output logic [NUM_UNITS-1:0]       unit_en,
  output logic [WIDTH-1:0]           unit_a,
  output logic [WIDTH-1:0]           unit_b,
  input  logic [NUM_UNITS*WIDTH-1:0] unit_res,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_zero,
  output logic [7:0]                 op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t               state_q;
  logic [2:0]           op_q;
  logic                 err_q;
  logic [3:0]           cnt_q;
  logic [NUM_UNITS-1:0] unit_en_q;
  logic [WIDTH-1:0]     unit_a_q;
  logic [WIDTH-1:0]     unit_b_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [WIDTH-1:0]     rsp_data_q;
  logic                 rsp_err_q;
  logic                 rsp_zero_q;
  logic [7:0]           op_count_q;

  logic                 op_ok_d;
  logic [NUM_UNITS-1:0] en_dec_d;
  logic [WIDTH-1:0]     res_sel_d;

  // An op is serviceable only if its index exists and the unit is populated.
  always_comb begin
    op_ok_d  = UNIT_MASK[req_op] && (32'(req_op) < NUM_UNITS);
    en_dec_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      en_dec_d[i] = (req_op == 3'(i));
    end
  end

  always_comb begin
    res_sel_d = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (op_q == 3'(i)) begin
        res_sel_d = unit_res[i*WIDTH +: WIDTH];
      end
    end
  end

  // Error ops pass through ISSUE for one cycle with no enable, so both the error
  // and the SETTLE=1 paths present rsp_valid one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      unit_en_q   <= '0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            unit_a_q    <= req_a;
            unit_b_q    <= req_b;
            req_ready_q <= 1'b0;
            state_q     <= ISSUE;
            if (op_ok_d) begin
              err_q     <= 1'b0;
              unit_en_q <= en_dec_d;
              cnt_q     <= SETTLE_M1;
            end else begin
              err_q     <= 1'b1;
              cnt_q     <= '0;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == 4'd0) begin
            unit_en_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_data_q  <= err_q ? '0 : res_sel_d;
            rsp_zero_q  <= err_q || (res_sel_d == '0);
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            op_count_q  <= op_count_q + 8'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign unit_en   = unit_en_q;
  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = rsp_zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
// Bench for alu_op_dispatch: two instances (SETTLE=1/mask 7F and SETTLE=4/mask FF)
// driven by vector tables, hand sequences and random ops against a unit-level model.
module tb_alu_op_dispatch;
  localparam int W = 4;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n     [2];
  logic           req_valid [2];
  logic           req_ready [2];
  logic [2:0]     req_op    [2];
  logic [W-1:0]   req_a     [2];
  logic [W-1:0]   req_b     [2];
  logic [N-1:0]   unit_en   [2];
  logic [W-1:0]   unit_a    [2];
  logic [W-1:0]   unit_b    [2];
  logic [N*W-1:0] unit_res  [2];
  logic           rsp_valid [2];
  logic           rsp_ready [2];
  logic [W-1:0]   rsp_data  [2];
  logic           rsp_err   [2];
  logic           rsp_zero  [2];
  logic [7:0]     op_count  [2];

  int checks = 0;
  int errors = 0;
  int exp_cnt [2];
  logic [3:0] junk = 4'd0;

  localparam logic [7:0] MASK [2] = '{8'h7F, 8'hFF};
  localparam int         STL  [2] = '{1, 4};

  alu_op_dispatch #(.WIDTH(W), .NUM_UNITS(N), .SETTLE(1), .UNIT_MASK(8'h7F)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]), .unit_en(unit_en[0]),
    .unit_a(unit_a[0]), .unit_b(unit_b[0]), .unit_res(unit_res[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .rsp_zero(rsp_zero[0]), .op_count(op_count[0]));

  alu_op_dispatch #(.WIDTH(W), .NUM_UNITS(N), .SETTLE(4), .UNIT_MASK(8'hFF)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]), .unit_en(unit_en[1]),
    .unit_a(unit_a[1]), .unit_b(unit_b[1]), .unit_res(unit_res[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .rsp_zero(rsp_zero[1]), .op_count(op_count[1]));

  // Behaviour of each functional unit as seen by a consumer.
  function automatic logic [3:0] ref_unit(input int u, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    case (u)
      0: r = {3'b000, (a != 4'd0) && (b != 4'd0)};
      1: r = {3'b000, (a != 4'd0) || (b != 4'd0)};
      2: r = a & b;
      3: r = a + b;
      4: r = a - b;
      5: r = a ^ b;
      6: r = a | b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  always @(posedge clk) junk <= junk + 4'd7;

  // Disabled units drive changing garbage so a mistimed capture shows up.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      unit_res[d] = '0;
      for (int u = 0; u < N; u++) begin
        unit_res[d][u*W +: W] = unit_en[d][u] ? ref_unit(u, unit_a[d], unit_b[d]) : (junk ^ 4'(u));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1) begin
        chk("en_onehot0", 32'($onehot0(unit_en[d])), 32'd1);
        chk("en_outside_issue", 32'((req_ready[d] || rsp_valid[d]) && (unit_en[d] != '0)), 32'd0);
      end
    end
  end

  task automatic do_op(input string tag, input int d, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input int stall,
                       input logic [3:0] xd, input logic xe, input logic xz,
                       input int xen, input int xlat);
    int n;
    int en_cyc;
    logic [3:0] held;
    @(negedge clk);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_op[d] = op; req_a[d] = a; req_b[d] = b;
    rsp_ready[d] = (stall == 0);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_op[d] = 3'($urandom); req_a[d] = 4'($urandom); req_b[d] = 4'($urandom);
    chk({tag, "_unit_a"}, 32'(unit_a[d]), 32'(a));
    chk({tag, "_unit_b"}, 32'(unit_b[d]), 32'(b));
    n = 0;
    en_cyc = 0;
    while (n < 40 && rsp_valid[d] !== 1'b1) begin
      if (unit_en[d] != '0) begin
        en_cyc++;
        chk({tag, "_en_bit"}, 32'(unit_en[d]), 32'(8'h01 << op));
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(xlat));
    chk({tag, "_en_cycles"}, 32'(en_cyc), 32'(xen));
    chk({tag, "_data"}, 32'(rsp_data[d]), 32'(xd));
    chk({tag, "_err"}, 32'(rsp_err[d]), 32'(xe));
    chk({tag, "_zero"}, 32'(rsp_zero[d]), 32'(xz));
    held = xd;
    for (int s = 0; s < stall; s++) begin
      req_valid[d] = (s % 2 == 0);
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({tag, "_stall_data"}, 32'(rsp_data[d]), 32'(held));
      chk({tag, "_stall_ready"}, 32'(req_ready[d]), 32'd0);
      chk({tag, "_stall_opa"}, 32'(unit_a[d]), 32'(a));
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    exp_cnt[d] = (exp_cnt[d] + 1) % 256;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid[d]), 32'd0);
    chk({tag, "_ready_back"}, 32'(req_ready[d]), 32'd1);
    chk({tag, "_op_count"}, 32'(op_count[d]), 32'(exp_cnt[d]));
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] data;
    logic       err;
    logic       zero;
    int         en;
    int         lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] op;
    logic [3:0] a, b, xd;
    logic       xe;

    tbl[0] = '{3'd0, 4'h3, 4'h5, 4'h1, 1'b0, 1'b0, 1, 1};
    tbl[1] = '{3'd0, 4'h0, 4'h9, 4'h0, 1'b0, 1'b1, 1, 1};
    tbl[2] = '{3'd3, 4'hF, 4'h2, 4'h1, 1'b0, 1'b0, 1, 1};
    tbl[3] = '{3'd7, 4'h1, 4'h1, 4'h0, 1'b1, 1'b1, 0, 1};
    tbl[4] = '{3'd2, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1, 1};
    tbl[5] = '{3'd4, 4'h2, 4'h3, 4'hF, 1'b0, 1'b0, 1, 1};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_op[d] = '0;
      req_a[d] = '0; req_b[d] = '0; rsp_ready[d] = 1'b0; exp_cnt[d] = 0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_unit_en", 32'(unit_en[d]), 32'd0);
      chk("rst_unit_a", 32'(unit_a[d]), 32'd0);
      chk("rst_unit_b", 32'(unit_b[d]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data[d]), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero[d]), 32'd0);
      chk("rst_op_count", 32'(op_count[d]), 32'd0);
    end
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("tbl%0d", i), 0, tbl[i].op, tbl[i].a, tbl[i].b, 0,
            tbl[i].data, tbl[i].err, tbl[i].zero, tbl[i].en, tbl[i].lat);
    end

    // SETTLE=4 instance: long enable window, response stall with ignored requests.
    do_op("stall5", 1, 3'd3, 4'h7, 4'h8, 5, 4'hF, 1'b0, 1'b0, 4, 4);
    do_op("op7_pop", 1, 3'd7, 4'h5, 4'h0, 0, 4'hA, 1'b0, 1'b0, 4, 4);
    do_op("oring0", 1, 3'd1, 4'h0, 4'h0, 2, 4'h0, 1'b0, 1'b1, 4, 4);

    // Asynchronous reset while a unit is enabled.
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = 3'd5; req_a[1] = 4'h3; req_b[1] = 4'h6; rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("mid_issue_en", 32'(unit_en[1]), 32'h20);
    @(posedge clk); #2;
    rst_n[1] = 1'b0;
    #1;
    chk("arst_unit_en", 32'(unit_en[1]), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("arst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("arst_op_count", 32'(op_count[1]), 32'd0);
    exp_cnt[1] = 0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    do_op("after_arst", 1, 3'd6, 4'h3, 4'h4, 0, 4'h7, 1'b0, 1'b0, 4, 4);

    // Random back-to-back traffic with a fresh counter so it wraps at op 256.
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    exp_cnt[0] = 0;
    for (int i = 0; i < 256; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom);
      b  = 4'($urandom);
      xe = !MASK[0][op];
      xd = xe ? 4'h0 : ref_unit(int'(op), a, b);
      do_op("rnd", 0, op, a, b, 0, xd, xe, (xd == 4'h0),
            xe ? 0 : STL[0], xe ? 1 : STL[0]);
      if (i == 254) chk("cnt_at_ff", 32'(op_count[0]), 32'hFF);
    end
    chk("cnt_wrapped", 32'(op_count[0]), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
